// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle RV32I sequencer: IF/ID/EX/MEM/WB stepping, memory handshake and datapath write enables.
// Optional cycle/instret counters under `ifdef MC_CPU_CTRL_PERF_EN.
module mc_cpu_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        pc_init,
  output logic        halted,
  output logic [2:0]  state
`ifdef MC_CPU_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
    S_MEM  = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic       op_known;

  // Only the opcode steers sequencing; the PC value itself lives in the datapath.
  logic unused_ok;
  assign unused_ok = ^{inst[31:7], RESET_PC};

  assign opcode = inst[6:0];
  assign state  = state_q;

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_known = 1'b1;
      default:                           op_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    pc_init      = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          pc_init = 1'b1;
          state_d = S_IF;
        end
      end
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (opcode == OP_SYSTEM) state_d = S_HALT;
        else if (!op_known) begin
          pc_we   = 1'b1;
          state_d = S_IF;
        end else state_d = S_EX;
      end
      S_EX: begin
        if (opcode == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = br_taken;
          state_d = S_IF;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_MEM: begin
        // mem_we/mem_addr_sel come from state and IR only, so they hold for the whole request.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_src  = (opcode == OP_JAL || opcode == OP_JALR);
        state_d = S_IF;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef MC_CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (pc_we) instret_cnt_d = instret_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// Directed table-driven bench for mc_cpu_ctrl; each row is one clock cycle of inputs and expected outputs.
module tb_mc_cpu_ctrl;
  logic        clk = 1'b0;
  logic        rstn, run, br_taken, mem_ready;
  logic [31:0] inst;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_src, pc_init, halted;
  logic [2:0]  state;
`ifdef MC_CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  mc_cpu_ctrl dut (
    .clk(clk), .rstn(rstn), .run(run), .inst(inst), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we),
    .pc_we(pc_we), .pc_src(pc_src), .pc_init(pc_init), .halted(halted), .state(state)
`ifdef MC_CPU_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADD = 32'h003100B3, LW = 32'h00012083, SW = 32'h00112023;
  localparam logic [31:0] BEQ = 32'h00208063, JAL = 32'h0000006F, ILL = 32'h00000000;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [2:0] IDLE = 3'd0, IF_ = 3'd1, ID = 3'd2, EX = 3'd3, MEM = 3'd4, WB = 3'd5, HLT = 3'd6;
  // {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_src, pc_init, halted}
  localparam logic [9:0] REQ = 10'h200, WE = 10'h100, SEL = 10'h080, IR = 10'h040, MDR = 10'h020;
  localparam logic [9:0] RF = 10'h010, PCW = 10'h008, PCS = 10'h004, INIT = 10'h002, HALTO = 10'h001;

  typedef struct {
    logic        rstn, run;
    logic [31:0] inst;
    logic        br, rdy;
    logic [2:0]  st;
    logic [9:0]  outs;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0, n_fail = 0;

  task automatic v(input logic r, input logic ru, input logic [31:0] in, input logic b,
                   input logic rd, input logic [2:0] s, input logic [9:0] o);
    vec_t t;
    t = '{rstn: r, run: ru, inst: in, br: b, rdy: rd, st: s, outs: o};
    vq.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [9:0] act;
    @(negedge clk);
    rstn = t.rstn; run = t.run; inst = t.inst; br_taken = t.br; mem_ready = t.rdy;
    #1;
    act = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_src, pc_init, halted};
    n_tests++;
    if (state !== t.st || act !== t.outs) begin
      n_fail++;
      $display("FAIL vec%0d: state=%0d outs=%b, required state=%0d outs=%b", idx, state, act, t.st, t.outs);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; run = 1'b0; inst = ADD; br_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    // rstn run inst  br rdy  state  outputs
    v(1, 0, ADD, 0, 1, IDLE, 0);                 // reset state
    v(1, 1, ADD, 0, 1, IDLE, INIT);
    v(1, 0, ADD, 0, 1, IF_,  REQ | IR);
    v(1, 0, ADD, 0, 1, ID,   0);
    v(1, 0, ADD, 0, 1, EX,   0);
    v(1, 0, ADD, 0, 1, WB,   RF | PCW);
    v(1, 0, LW,  0, 1, IF_,  REQ | IR);          // lw with 3 wait states
    v(1, 0, LW,  0, 1, ID,   0);
    v(1, 0, LW,  0, 1, EX,   0);
    v(1, 0, LW,  0, 0, MEM,  REQ | SEL);
    v(1, 0, LW,  0, 0, MEM,  REQ | SEL);
    v(1, 0, LW,  0, 0, MEM,  REQ | SEL);
    v(1, 0, LW,  0, 1, MEM,  REQ | SEL | MDR);
    v(1, 0, LW,  0, 1, WB,   RF | PCW);
    v(1, 0, SW,  0, 1, IF_,  REQ | IR);          // sw
    v(1, 0, SW,  0, 1, ID,   0);
    v(1, 0, SW,  0, 1, EX,   0);
    v(1, 0, SW,  0, 1, MEM,  REQ | WE | SEL | PCW);
    v(1, 0, BEQ, 0, 0, IF_,  REQ);               // fetch wait state
    v(1, 0, BEQ, 0, 1, IF_,  REQ | IR);
    v(1, 0, BEQ, 0, 1, ID,   0);
    v(1, 0, BEQ, 1, 1, EX,   PCW | PCS);         // taken
    v(1, 0, BEQ, 0, 1, IF_,  REQ | IR);
    v(1, 0, BEQ, 0, 1, ID,   0);
    v(1, 0, BEQ, 0, 1, EX,   PCW);               // not taken
    v(1, 0, JAL, 0, 1, IF_,  REQ | IR);
    v(1, 0, JAL, 0, 1, ID,   0);
    v(1, 0, JAL, 0, 1, EX,   0);
    v(1, 0, JAL, 0, 1, WB,   RF | PCW | PCS);
    v(1, 0, ILL, 0, 1, IF_,  REQ | IR);          // unknown opcode acts as NOP
    v(1, 0, ILL, 0, 1, ID,   PCW);
    v(1, 0, EBRK, 0, 1, IF_, REQ | IR);
    v(1, 0, EBRK, 0, 1, ID,  0);
    v(1, 1, EBRK, 0, 1, HLT, HALTO);             // run ignored in HALT
    v(1, 0, EBRK, 0, 1, HLT, HALTO);
    v(1, 1, EBRK, 0, 1, HLT, HALTO);
    v(0, 0, EBRK, 0, 1, HLT, HALTO);
    v(1, 0, ADD, 0, 1, IDLE, 0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Hand sequence: counters after one add, then reset during a MEM wait.
    vq.delete();
    v(1, 1, ADD, 0, 1, IDLE, INIT);
    v(1, 0, ADD, 0, 1, IF_,  REQ | IR);
    v(1, 0, ADD, 0, 1, ID,   0);
    v(1, 0, ADD, 0, 1, EX,   0);
    v(1, 0, ADD, 0, 1, WB,   RF | PCW);
    v(1, 0, LW,  0, 1, IF_,  REQ | IR);
    v(1, 0, LW,  0, 1, ID,   0);
    v(1, 0, LW,  0, 1, EX,   0);
    v(1, 0, LW,  0, 0, MEM,  REQ | SEL);
    v(0, 0, LW,  0, 0, MEM,  REQ | SEL);
    v(1, 0, LW,  0, 1, IDLE, 0);
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], 100 + i);
`ifdef MC_CPU_CTRL_PERF_EN
      if (i == 5) begin
        check32("cycle_cnt_after_add", cycle_cnt, 32'd4);
        check32("instret_after_add", instret_cnt, 32'd1);
      end
      if (i == 10) begin
        check32("cycle_cnt_after_rst", cycle_cnt, 32'd0);
        check32("instret_after_rst", instret_cnt, 32'd0);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
